// File: rtl/rx_sample_fifo.sv
// rx_sample_fifo: packs 32-bit IQ samples into 128-bit words, buffers them
// in a first-word-fall-through FIFO and presents them as an AXI-Stream master.
// Optional feature macro: RX_SAMPLE_TEST_PATTERN_EN (adds test_mode port and
// a counting pattern that replaces s_sample while test_mode is high).
module rx_sample_fifo #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [8:0]        burst_len,
    input  logic [31:0]       s_sample,
    input  logic              s_sample_valid,
    output logic [127:0]      m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              rx_fifo_data_ready,
    output logic [ADDR_W:0]   occupancy,
    output logic              overflow,
    output logic [15:0]       overflow_count
`ifdef RX_SAMPLE_TEST_PATTERN_EN
    ,
    input  logic              test_mode
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [1:0]        pack_idx;
    logic [127:0]      pack_reg;
    logic              word_pend;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [127:0]      mem [DEPTH];
    logic              enable_q;
    logic              accept;
    logic              pop;
    logic              do_write;
    logic              drop;
    logic [31:0]       sample_in;
    logic [ADDR_W:0]   occ_next;

    assign accept   = s_sample_valid && enable;
    assign pop      = m_axis_tvalid && m_axis_tready;
    // Occupancy never exceeds DEPTH, so its MSB alone flags a full FIFO.
    assign do_write = word_pend && (!occupancy[ADDR_W] || pop);
    assign drop     = word_pend && enable && !do_write;

    assign m_axis_tvalid = (occupancy != '0);
    assign m_axis_tdata  = mem[rd_ptr];

`ifdef RX_SAMPLE_TEST_PATTERN_EN
    logic [31:0] pattern_cnt;

    // Pattern counter: cleared while disabled, advances per accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable)
            pattern_cnt <= '0;
        else if (accept)
            pattern_cnt <= pattern_cnt + 32'd1;
    end

    assign sample_in = test_mode ? pattern_cnt : s_sample;
`else
    assign sample_in = s_sample;
`endif

    // Next occupancy: simultaneous write and pop cancel out.
    always_comb begin
        occ_next = occupancy;
        if (do_write && !pop)
            occ_next = occupancy + (ADDR_W+1)'(1);
        else if (pop && !do_write)
            occ_next = occupancy - (ADDR_W+1)'(1);
    end

    // Packer data lane: drop each accepted sample into its 32-bit slot.
    always_ff @(posedge clk) begin
        if (accept)
            pack_reg[{pack_idx, 5'd0} +: 32] <= sample_in;
    end

    // Storage write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= pack_reg;
    end

    // Packer control, pointers, occupancy and burst threshold; enable low flushes.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            pack_idx           <= '0;
            word_pend          <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            occupancy          <= '0;
            rx_fifo_data_ready <= 1'b0;
        end else begin
            word_pend <= accept && (pack_idx == 2'd3);
            if (accept)
                pack_idx <= pack_idx + 2'd1;
            if (do_write)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            occupancy          <= occ_next;
            rx_fifo_data_ready <= (burst_len != 9'd0) &&
                                  (32'(occ_next) >= 32'(burst_len));
        end
    end

    // Drop statistics: survive a flush, clear the cycle after enable rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q       <= 1'b0;
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                overflow       <= 1'b0;
                overflow_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (overflow_count != '1)
                    overflow_count <= overflow_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Testbench for rx_sample_fifo (ADDR_W=4): directed scenarios plus random
// traffic, checked against a queue-based model of the packer and FIFO.
module tb_rx_sample_fifo;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [8:0]    burst_len = 9'd4;
    logic [31:0]   s_sample = '0;
    logic          s_sample_valid = 1'b0;
    logic [127:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          rx_fifo_data_ready;
    logic [ADDR_W:0] occupancy;
    logic          overflow;
    logic [15:0]   overflow_count;
`ifdef RX_SAMPLE_TEST_PATTERN_EN
    logic          test_mode = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [127:0] q[$];
    bit [31:0]  part[$];
    bit         pend;
    bit [127:0] pend_word;
    int unsigned pat;
    bit         m_rdy;
    bit         m_ovf;
    bit [15:0]  m_cnt;
    bit         m_en_q;
    bit         m_tm;

    rx_sample_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .burst_len(burst_len),
        .s_sample(s_sample),
        .s_sample_valid(s_sample_valid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .rx_fifo_data_ready(rx_fifo_data_ready),
        .occupancy(occupancy),
        .overflow(overflow),
        .overflow_count(overflow_count)
`ifdef RX_SAMPLE_TEST_PATTERN_EN
        ,
        .test_mode(test_mode)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1);
    end

    task automatic model_clear();
        q.delete(); part.delete();
        pend = 0; pat = 0; m_rdy = 0; m_ovf = 0; m_cnt = 0; m_en_q = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input bit en, input bit v, input logic [31:0] s, input bit rd);
        bit pop;
        enable = en; s_sample_valid = v; s_sample = s; m_axis_tready = rd;
`ifdef RX_SAMPLE_TEST_PATTERN_EN
        test_mode = m_tm;
`endif
        @(posedge clk);
        pop = (q.size() != 0) && rd;
        if (!en) begin
            q.delete(); part.delete(); pend = 0; pat = 0; m_rdy = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (pend) begin
                if (q.size() < DEPTH) q.push_back(pend_word);
                else begin
                    m_ovf = 1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
            end
            pend = 0;
            if (v) begin
                part.push_back(m_tm ? pat : s);
                pat++;
                if (part.size() == 4) begin
                    pend_word = {part[3], part[2], part[1], part[0]};
                    pend = 1;
                    part.delete();
                end
            end
            m_rdy = (burst_len != 0) && (q.size() >= int'(burst_len));
        end
        if (en && !m_en_q) begin m_ovf = 0; m_cnt = 0; end
        m_en_q = en;
        #1;
    endtask

    task automatic do_reset(input bit en_during);
        rst_n = 0; enable = en_during; s_sample_valid = en_during; m_axis_tready = 0;
        @(posedge clk);
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        do_reset(0);
        do_reset(0);
        if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d, required 0", occupancy); end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", m_axis_tvalid); end
        checks++;
        if (rx_fifo_data_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b, required 0", rx_fifo_data_ready); end
        checks++;
        if (overflow !== 1'b0 || overflow_count !== 16'd0) begin
            errors++; $display("FAIL reset_ovf: got %b/%0d, required 0/0", overflow, overflow_count);
        end
        checks++;
        rst_n = 1;
    endtask

    task automatic test_ramp();
        burst_len = 9'd4;
        for (int i = 1; i <= 4; i++) step(1, 1, 32'(i), 1);
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ramp_early: tvalid got %b, required 0", m_axis_tvalid); end
        checks++;
        step(1, 0, 0, 1);
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL ramp_tvalid: got %b, required 1", m_axis_tvalid); end
        checks++;
        if (m_axis_tdata !== 128'h00000004_00000003_00000002_00000001) begin
            errors++; $display("FAIL ramp_tdata: got %h, required 00000004000000030000000200000001", m_axis_tdata);
        end
        checks++;
        step(1, 0, 0, 1);
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ramp_one_beat: tvalid got %b, required 0", m_axis_tvalid); end
        checks++;
    endtask

    task automatic test_threshold();
        step(0, 0, 0, 0);
        burst_len = 9'd16;
        for (int i = 0; i < 66; i++) begin
            step(1, i < 64, $urandom, 0);
            if (occupancy !== 5'(q.size())) begin
                errors++; $display("FAIL thr_occ: got %0d, required %0d", occupancy, q.size());
            end
            checks++;
            if (rx_fifo_data_ready !== (q.size() >= 16)) begin
                errors++; $display("FAIL thr_rdy: got %b, required %b at occ %0d", rx_fifo_data_ready, q.size() >= 16, q.size());
            end
            checks++;
        end
        burst_len = 9'd0;
        step(1, 0, 0, 0);
        if (rx_fifo_data_ready !== 1'b0 || occupancy !== 5'd16) begin
            errors++; $display("FAIL thr_zero: rdy/occ got %b/%0d, required 0/16", rx_fifo_data_ready, occupancy);
        end
        checks++;
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 0);
        burst_len = 9'd8;
        for (int i = 0; i < 80; i++) step(1, 1, 32'(i), 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        if (occupancy !== 5'd16 || overflow !== 1'b1 || overflow_count !== 16'd4) begin
            errors++; $display("FAIL ovf_state: occ/ovf/cnt got %0d/%b/%0d, required 16/1/4", occupancy, overflow, overflow_count);
        end
        checks++;
        for (int k = 0; k < 16; k++) begin
            logic [127:0] exp;
            exp = {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
                errors++; $display("FAIL ovf_drain: word %0d got %b/%h, required 1/%h", k, m_axis_tvalid, m_axis_tdata, exp);
            end
            checks++;
            step(1, 0, 0, 1);
        end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_empty: tvalid got %b, required 0", m_axis_tvalid); end
        checks++;
    endtask

    task automatic test_flush();
        logic [31:0] s [4];
        for (int i = 0; i < 6; i++) step(1, 1, $urandom, 0);
        step(0, 1, $urandom, 0);
        if (overflow_count !== 16'd4 || overflow !== 1'b1 || occupancy !== 5'd0) begin
            errors++; $display("FAIL flush_hold: cnt/ovf/occ got %0d/%b/%0d, required 4/1/0", overflow_count, overflow, occupancy);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            s[i] = $urandom;
            step(1, 1, s[i], 0);
            if (i == 0 && (overflow_count !== 16'd0 || overflow !== 1'b0)) begin
                errors++; $display("FAIL flush_clear: cnt/ovf got %0d/%b, required 0/0", overflow_count, overflow);
            end
            if (i == 0) checks++;
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        if (occupancy !== 5'd1 || m_axis_tdata !== {s[3], s[2], s[1], s[0]}) begin
            errors++; $display("FAIL flush_word: occ/data got %0d/%h, required 1/%h", occupancy, m_axis_tdata, {s[3], s[2], s[1], s[0]});
        end
        checks++;
        step(1, 0, 0, 1);
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL flush_single: tvalid got %b, required 0", m_axis_tvalid); end
        checks++;
    endtask

    task automatic test_full_pop();
        step(0, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(1, 1, $urandom, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, $urandom, 0);
        step(1, 0, 0, 1);
        if (occupancy !== 5'd16 || overflow_count !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL full_pop: occ/cnt/ovf got %0d/%0d/%b, required 16/0/0", occupancy, overflow_count, overflow);
        end
        checks++;
        for (int k = 0; k < 16; k++) begin
            if (m_axis_tdata !== q[0]) begin
                errors++; $display("FAIL full_pop_data: word %0d got %h, required %h", k, m_axis_tdata, q[0]);
            end
            checks++;
            step(1, 0, 0, 1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 49) == 0) burst_len = 9'($urandom_range(0, 20));
            step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0);
            if (occupancy !== 5'(q.size())) begin
                errors++; $display("FAIL rnd_occ: cycle %0d got %0d, required %0d", c, occupancy, q.size());
            end
            checks++;
            if (m_axis_tvalid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_tvalid: cycle %0d got %b, required %b", c, m_axis_tvalid, q.size() != 0);
            end
            checks++;
            if (q.size() != 0) begin
                if (m_axis_tdata !== q[0]) begin
                    errors++; $display("FAIL rnd_tdata: cycle %0d got %h, required %h", c, m_axis_tdata, q[0]);
                end
                checks++;
            end
            if (rx_fifo_data_ready !== m_rdy) begin
                errors++; $display("FAIL rnd_rdy: cycle %0d got %b, required %b", c, rx_fifo_data_ready, m_rdy);
            end
            checks++;
            if (overflow !== m_ovf || overflow_count !== m_cnt) begin
                errors++; $display("FAIL rnd_ovf: cycle %0d got %b/%0d, required %b/%0d", c, overflow, overflow_count, m_ovf, m_cnt);
            end
            checks++;
        end
    endtask

`ifdef RX_SAMPLE_TEST_PATTERN_EN
    task automatic test_pattern();
        step(0, 0, 0, 0);
        m_tm = 1;
        for (int i = 0; i < 8; i++) step(1, 1, $urandom, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        if (occupancy !== 5'd2 || m_axis_tdata !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
            errors++; $display("FAIL pattern_w0: occ/data got %0d/%h, required 2/{3,2,1,0}", occupancy, m_axis_tdata);
        end
        checks++;
        step(1, 0, 0, 1);
        if (m_axis_tdata !== {32'd7, 32'd6, 32'd5, 32'd4}) begin
            errors++; $display("FAIL pattern_w1: got %h, required {7,6,5,4}", m_axis_tdata);
        end
        checks++;
        m_tm = 0;
        step(1, 0, 0, 1);
    endtask
`endif

    task automatic test_reset_midop();
        for (int i = 0; i < 40; i++) step(1, 1, $urandom, 0);
        do_reset(1);
        if (occupancy !== 5'd0 || m_axis_tvalid !== 1'b0 || rx_fifo_data_ready !== 1'b0) begin
            errors++; $display("FAIL midop_reset: occ/tvalid/rdy got %0d/%b/%b, required 0/0/0", occupancy, m_axis_tvalid, rx_fifo_data_ready);
        end
        checks++;
        rst_n = 1;
        for (int i = 0; i < 4; i++) step(1, 1, 32'(i + 10), 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        if (occupancy !== 5'd1 || m_axis_tdata !== {32'd13, 32'd12, 32'd11, 32'd10}) begin
            errors++; $display("FAIL midop_resume: occ/data got %0d/%h, required 1/{13,12,11,10}", occupancy, m_axis_tdata);
        end
        checks++;
    endtask

    initial begin
        m_tm = 0;
        model_clear();
        test_reset();
        test_ramp();
        test_threshold();
        test_overflow();
        test_flush();
        test_full_pop();
        test_random();
`ifdef RX_SAMPLE_TEST_PATTERN_EN
        test_pattern();
`endif
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_sample_fifo.md
# rx_sample_fifo

Upstream feeder for the RX DDR write DMA. Packs 32-bit IQ samples from the ADC datapath, which cannot be back-pressured, into 128-bit words. Buffers the words in a first-word-fall-through FIFO and presents them as a 128-bit AXI-Stream master. Drives `rx_fifo_data_ready` to the DMA when at least one burst's worth of words is buffered, and counts dropped words on overflow.

## Interface
- `ADDR_W`, default 10: FIFO depth is 2^ADDR_W words of 128 bits. Legal range is 4 to 12.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low. Clock is `clk`.
- `enable`, input, 1: capture enable. Low flushes the block.
- `burst_len`, input, 9: burst length in 128-bit beats. Same value as given to the DMA.
- `s_sample`, input, 32: sample; I in [15:0], Q in [31:16].
- `s_sample_valid`, input, 1: sample strobe. There is no ready.
- `m_axis_tdata`, output, 128: packed word.
- `m_axis_tvalid`, output, 1: word available.
- `m_axis_tready`, input, 1: consumer accepts the word.
- `rx_fifo_data_ready`, output, 1: occupancy >= `burst_len`.
- `occupancy`, output, ADDR_W+1: words currently stored.
- `overflow`, output, 1: sticky; a word was dropped.
- `overflow_count`, output, 16: dropped-word count; saturates at 0xFFFF.
- `test_mode`, input, 1: present only with `RX_SAMPLE_TEST_PATTERN_EN` defined.

## Operation
- **Packer**
  - 2-bit `pack_idx` and a 128-bit `pack_reg`.
  - An accepted sample (valid && enable) is written to `pack_reg[32*pack_idx +: 32]`, then `pack_idx` increments.
  - Sample 0 occupies [31:0]; sample 3 occupies [127:96].
  - When sample 3 is written, `word_pend` is set for one cycle.
- **FIFO write**
  - A `word_pend` cycle writes `pack_reg` to `mem[wr_ptr]` and increments `wr_ptr`, but only if `occupancy < 2^ADDR_W` or a pop occurs in the same cycle.
  - Otherwise the word is dropped: `overflow` is set and `overflow_count` increments (saturating).
- **FIFO read (FWFT)**
  - `m_axis_tdata = mem[rd_ptr]`, asynchronous LUTRAM read.
  - `m_axis_tvalid = (occupancy != 0)`.
  - A pop occurs when tvalid && tready; `rd_ptr` increments.
- **Occupancy**
  - +1 on write only, -1 on pop only, unchanged when both occur in the same cycle.
  - Pointers are ADDR_W bits and wrap naturally.
- **`rx_fifo_data_ready`**: registered; equals `(burst_len != 0) && (occupancy >= burst_len)` evaluated on the post-update occupancy.
- **Enable low (flush)**: `pack_idx`, `word_pend`, both pointers, `occupancy` and `rx_fifo_data_ready` clear on the next edge. Samples arriving during that cycle are discarded. A partially packed word is discarded.
- **Overflow statistics**: `overflow` and `overflow_count` hold through a flush. They clear on reset and on the cycle after an `enable` rising edge.

## Timing
- **Reset values**: `m_axis_tvalid`=0, `rx_fifo_data_ready`=0, `occupancy`=0, `overflow`=0, `overflow_count`=0, `pack_idx`=0, pointers=0. `m_axis_tdata` is undefined until the first write.
- **Packing latency**: 4th sample accepted in cycle N. `word_pend` is high in cycle N+1. The RAM write happens at the end of N+1. `m_axis_tvalid` and `occupancy` update in N+2. `rx_fifo_data_ready` updates in N+2.
- **Throughput**: one sample per cycle, i.e. one word per 4 cycles. Reads can sustain one word per cycle.
- **Full FIFO**: a write with a simultaneous pop succeeds; occupancy stays at 2^ADDR_W.
- **Changing `burst_len`**: takes effect on the next edge. No other state is affected.
- **Reset mid-operation**: all buffered data is lost. Outputs reach reset values at the first edge with `rst_n`=0.

## Configuration
- Macro: `RX_SAMPLE_TEST_PATTERN_EN`.
- **Defined**:
  - The `test_mode` port exists, along with a 32-bit `pattern_cnt`. `pattern_cnt` clears while `enable` is low and increments per accepted sample.
  - With `test_mode`=1, the packer stores `pattern_cnt` in place of `s_sample`.
- **Undefined**: no port and no counter; `s_sample` is always packed.

## Test plan
- **Ramp pack**: enable=1; feed samples 0x00000001..0x00000004 on consecutive cycles; tready=1.
  - tvalid rises 2 cycles after the 4th sample.
  - tdata = 0x00000004_00000003_00000002_00000001.
  - One beat, then tvalid=0.
- **Data-ready threshold**: burst_len=16, tready=0; feed 64 samples.
  - `rx_fifo_data_ready` rises in the same cycle `occupancy` reaches 16, not before.
  - burst_len=0 keeps it at 0 for any occupancy.
- **Overflow**: ADDR_W=4, tready=0; feed 80 samples (20 words).
  - `occupancy`=16, `overflow`=1, `overflow_count`=4.
  - Draining yields words 0..15 in order.
- **Full with simultaneous pop**: hold occupancy at 16. A word completes in the same cycle as a pop.
  - No drop; `occupancy` stays 16; `overflow_count` unchanged.
- **Flush mid-word**: feed 6 samples, then drop enable for one cycle, then re-enable and feed 4 samples.
  - Exactly one word appears, containing only the last 4 samples.
  - `overflow_count` cleared after the rising edge of enable.
- **Test pattern**: with `RX_SAMPLE_TEST_PATTERN_EN` defined and test_mode=1; feed 8 arbitrary samples.
  - Words = {3,2,1,0} and {7,6,5,4}.
